// File: rtl/qrd_pkg.sv
// Shared QRD definitions: complex element layout, issuer states, row start-offset function.
// Latency: none (types and constant functions only).
// Backpressure: n/a.
//
// Used by the row scheduler, the QRD core and the bench so that all three
// agree on where each row of the skewed schedule begins.
package qrd_pkg;

  // Default component width of the complex datapath.
  localparam int QRD_W = 14;

  // Complex element: real part in the upper half, imaginary part in the lower
  // half. Parameterised blocks use the same {r, i} packing on 2*W-bit vectors.
  typedef struct packed {
    logic signed [QRD_W-1:0] r;
    logic signed [QRD_W-1:0] i;
  } cplx_t;

  // Issuer states of the row scheduler.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } iss_state_e;

  // Start cycle of row k (1-based) within one matrix schedule:
  // row 1 at 0, row 2 at skew, every later row a further row_gap cycles on.
  function automatic int st(input int k, input int skew, input int row_gap);
    if (k <= 1) begin
      return 0;
    end
    return skew + (k - 2) * row_gap;
  endfunction

endpackage

// File: rtl/qrd_pingpong_mem.sv
// Two-bank register file holding one augmented matrix [H|y] per bank.
// Latency: write lands on the clock edge; reads are combinational.
// Backpressure: none; the scheduler guarantees the written bank is never the one being read.
//
// Ports:
//   clk_i       clock
//   wr_en_i     write strobe
//   wr_bank_i   bank selected for writing
//   wr_ptr_i    row-major element index 0..N(N+1)-1 within the bank
//   wr_dat_i    element, {real, imag}
//   rd_bank_i   bank selected for reading
//   rd_col_i    per-row column index; port k reads row k at column rd_col_i[k]
//   rd_dat_o    per-row element, {real, imag}, port k on bits [k*2W +: 2W]
module qrd_pingpong_mem #(
  parameter int N  = 4,
  parameter int W  = 14,
  parameter int PW = 5,
  parameter int CW = 3
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic              wr_bank_i,
  input  logic [PW-1:0]     wr_ptr_i,
  input  logic [2*W-1:0]    wr_dat_i,
  input  logic              rd_bank_i,
  input  logic [N*CW-1:0]   rd_col_i,
  output logic [N*2*W-1:0]  rd_dat_o
);

  localparam int NE = N * (N + 1);

  // Storage carries no reset: validity is tracked by the scheduler's full flags.
  logic [2*W-1:0] mem_q [2][NE];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_bank_i][wr_ptr_i] <= wr_dat_i;
    end
  end

  // One read port per matrix row; the row index is fixed by the port number,
  // only the column moves as the schedule advances.
  for (genvar k = 0; k < N; k++) begin : g_rd
    logic [PW-1:0] addr;
    assign addr = PW'(k * (N + 1)) + PW'(rd_col_i[k*CW +: CW]);
    assign rd_dat_o[k*2*W +: 2*W] = mem_q[rd_bank_i][addr];
  end

endmodule

// File: rtl/qrd_row_scheduler.sv
// Input scheduler for the systolic QRD core: buffers [H|y] row-major and replays it as N skewed row streams.
// Latency: first row-1 element appears two cycles after the last input beat is accepted (one bubble), if core_ready.
// Backpressure: s_ready drops only while both ping-pong banks hold unissued matrices; core_ready gates only the start of issue.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   s_valid/s_ready     input element handshake; s_r/s_i signed element
//   core_ready          core can take a new matrix (sampled only while idle)
//   row_r/row_i         row k (1..N) on bits [(k-1)*W +: W], zero outside its window
//   row_f               diagonal flag of row k on bit k-1 (row N has none)
//   busy                high for each cycle of the issue schedule
//   issue_done          pulse on the final schedule cycle
module qrd_row_scheduler
  import qrd_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 14,
  parameter int SKEW    = 1,
  parameter int ROW_GAP = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [W-1:0]  s_r,
  input  logic signed [W-1:0]  s_i,
  input  logic                 core_ready,
  output logic [N*W-1:0]       row_r,
  output logic [N*W-1:0]       row_i,
  output logic [N-2:0]         row_f,
  output logic                 busy,
  output logic                 issue_done
);

  localparam int NE = N * (N + 1);
  localparam int PW = $clog2(NE);
  localparam int CW = $clog2(N + 1);
  localparam int L  = st(N, SKEW, ROW_GAP) + N + 1;
  localparam int TW = $clog2(L);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  iss_state_e     state_q, state_d;
  logic [TW-1:0]  t_q, t_d;
  logic [1:0]     full_q, full_d;
  logic           wr_bank_q, wr_bank_d;
  logic           rd_bank_q, rd_bank_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N*W-1:0] row_r_q, row_r_d;
  logic [N*W-1:0] row_i_q, row_i_d;
  logic [N-2:0]   row_f_q, row_f_d;

  logic             wr_en;
  logic [N-1:0]     in_win;
  logic [N-2:0]     flag_raw;
  logic [N*CW-1:0]  rd_col;
  logic [N*2*W-1:0] rd_dat;

  assign wr_en = s_valid && !full_q[wr_bank_q];

  // ---------------------------------------------------------------------------
  // Loader and issuer next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_ptr_d  = wr_ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_bank_q] && core_ready) begin
          state_d = ST_ISSUE;
          t_d     = '0;
        end
      end
      ST_ISSUE: begin
        // core_ready is deliberately not looked at here: a started schedule
        // always runs to completion.
        if (t_q == TW'(L - 1)) begin
          state_d           = ST_IDLE;
          t_d               = '0;
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
    endcase

    // The loader only ever writes a non-full bank, which can never be the bank
    // under issue, so both full-flag updates may land on the same edge.
    if (wr_en) begin
      if (wr_ptr_q == PW'(NE - 1)) begin
        wr_ptr_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Row windows for the cycle about to be presented (schedule time t_d).
  // Outputs are registered, so the data path looks one cycle ahead.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < N; k++) begin : g_row
    localparam int STK = st(k + 1, SKEW, ROW_GAP);
    // Extra top bit acts as a borrow: set when t_d is still before this row's start.
    logic [TW:0]   rel_x;
    logic [TW-1:0] rel;
    assign rel_x     = {1'b0, t_d} - {1'b0, TW'(STK)};
    assign rel       = rel_x[TW-1:0];
    assign in_win[k] = !rel_x[TW] && (rel < TW'(N + 1));
    assign rd_col[k*CW +: CW] = in_win[k] ? rel[CW-1:0] : '0;
    if (k < N - 1) begin : g_flag
      // Diagonal element of row k+1 sits at column k.
      assign flag_raw[k] = in_win[k] && (rel == TW'(k));
    end
  end

  qrd_pingpong_mem #(
    .N  (N),
    .W  (W),
    .PW (PW),
    .CW (CW)
  ) u_mem (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_bank_i (wr_bank_q),
    .wr_ptr_i  (wr_ptr_q),
    .wr_dat_i  ({s_r, s_i}),
    .rd_bank_i (rd_bank_q),
    .rd_col_i  (rd_col),
    .rd_dat_o  (rd_dat)
  );

  always_comb begin
    busy_d  = (state_d == ST_ISSUE);
    done_d  = busy_d && (t_d == TW'(L - 1));
    row_r_d = '0;
    row_i_d = '0;
    row_f_d = busy_d ? flag_raw : '0;
    for (int k = 0; k < N; k++) begin
      if (busy_d && in_win[k]) begin
        row_r_d[k*W +: W] = rd_dat[k*2*W + W +: W];
        row_i_d[k*W +: W] = rd_dat[k*2*W +: W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      t_q       <= '0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      row_r_q   <= '0;
      row_i_q   <= '0;
      row_f_q   <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      row_r_q   <= row_r_d;
      row_i_q   <= row_i_d;
      row_f_q   <= row_f_d;
    end
  end

  assign s_ready    = !full_q[wr_bank_q];
  assign busy       = busy_q;
  assign issue_done = done_q;
  assign row_r      = row_r_q;
  assign row_i      = row_i_q;
  assign row_f      = row_f_q;

endmodule

// File: tb/tb_qrd_row_scheduler.sv
module tb_qrd_row_scheduler;

  localparam int W = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         s_valid [2];
  logic [W-1:0] s_r     [2];
  logic [W-1:0] s_i     [2];
  logic         cr      [2];

  logic rdy    [2];
  logic busyv  [2];
  logic donev  [2];
  logic anyout [2];
  int   m_stored [2];
  int   mt       [2];
  bit   miss     [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Row start times straight from the schedule rules.
  function automatic int tb_st(input int k, input int sk, input int rg);
    if (k == 1) return 0;
    return sk + (k - 2) * rg;
  endfunction

  // Instance 0: N=4, SKEW=1, ROW_GAP=30.  Instance 1: N=2, SKEW=3, ROW_GAP=3.
  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int NN = (g == 0) ? 4 : 2;
    localparam int SK = (g == 0) ? 1 : 3;
    localparam int RG = (g == 0) ? 30 : 3;
    localparam int NE = NN * (NN + 1);
    localparam int LL = SK + (NN - 2) * RG + NN + 1;

    logic [NN*W-1:0] row_r, row_i;
    logic [NN-2:0]   row_f;
    logic            busy, done, sr;

    qrd_row_scheduler #(.N(NN), .W(W), .SKEW(SK), .ROW_GAP(RG)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid[g]),
      .s_ready    (sr),
      .s_r        (s_r[g]),
      .s_i        (s_i[g]),
      .core_ready (cr[g]),
      .row_r      (row_r),
      .row_i      (row_i),
      .row_f      (row_f),
      .busy       (busy),
      .issue_done (done)
    );

    // Reference model: matrices are queues of beats; an issue replays the
    // front matrix with row k delayed by its start time.
    bit              armed = 1'b0;
    bit              issuing = 1'b0;
    int              t = 0;
    int              stored = 0;
    int              s, idx;
    logic [2*W-1:0]  beats [$];
    logic [2*W-1:0]  part  [$];
    logic [2*W-1:0]  cur   [NE];
    logic [NN*W-1:0] er, ei;
    logic [NN-2:0]   ef;

    assign rdy[g]      = sr;
    assign busyv[g]    = busy;
    assign donev[g]    = done;
    assign anyout[g]   = |{row_r, row_i, row_f};
    assign m_stored[g] = stored;
    assign mt[g]       = t;
    assign miss[g]     = issuing;

    initial begin
      forever begin
        @(negedge clk);
        if (armed) begin
          er = '0; ei = '0; ef = '0;
          if (issuing) begin
            for (int k = 1; k <= NN; k++) begin
              s = tb_st(k, SK, RG);
              if (t >= s && t < s + NN + 1) begin
                idx = (k - 1) * (NN + 1) + (t - s);
                er[(k-1)*W +: W] = cur[idx][2*W-1:W];
                ei[(k-1)*W +: W] = cur[idx][W-1:0];
                if (k < NN && t == s + k - 1) ef[k-1] = 1'b1;
              end
            end
          end
          check($sformatf("i%0d_busy t=%0d", g, t), busy, issuing);
          check($sformatf("i%0d_issue_done t=%0d", g, t), done, issuing && (t == LL - 1));
          check($sformatf("i%0d_row_r t=%0d", g, t), row_r, er);
          check($sformatf("i%0d_row_i t=%0d", g, t), row_i, ei);
          check($sformatf("i%0d_row_f t=%0d", g, t), row_f, ef);
          check($sformatf("i%0d_s_ready", g), sr, stored < 2);
        end
        if (rst) begin
          armed = 1'b1; issuing = 1'b0; t = 0; stored = 0;
          beats.delete(); part.delete();
        end else if (armed) begin
          if (issuing) begin
            if (t == LL - 1) begin
              issuing = 1'b0; t = 0; stored--;
            end else begin
              t++;
            end
          end else if (beats.size() >= NE && cr[g]) begin
            issuing = 1'b1; t = 0;
            for (int e = 0; e < NE; e++) cur[e] = beats.pop_front();
          end
          if (s_valid[g] && sr) begin
            part.push_back({s_r[g], s_i[g]});
            if (part.size() == NE) begin
              foreach (part[e]) beats.push_back(part[e]);
              part.delete();
              stored++;
            end
          end
        end
      end
    end
  end

  // Drive nbeats elements into instance g; pattern mode uses (r,c) = 16r+c - j(16r+c).
  task automatic send(input int g, input int nbeats, input bit pat, input bit gaps, output int stalls);
    int  ncol, v, waited;
    bit  acc;
    ncol = (g == 0) ? 5 : 3;
    stalls = 0;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) begin
        s_valid[g] = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      v = 16 * (b / ncol) + (b % ncol);
      if (pat) begin
        s_r[g] = W'(v);
        s_i[g] = W'(-v);
      end else begin
        s_r[g] = W'($urandom);
        s_i[g] = W'($urandom);
      end
      s_valid[g] = 1'b1;
      acc = 1'b0;
      waited = 0;
      while (!acc && waited <= 400) begin
        @(negedge clk);
        acc = rdy[g];
        @(posedge clk); #1;
        if (!acc) begin stalls++; waited++; end
      end
      if (!acc) begin
        check($sformatf("i%0d_send_accept", g), acc, 1'b1);
        return;
      end
    end
  endtask

  task automatic drain(input int g, input int maxc);
    int c;
    c = 0;
    s_valid[g] = 1'b0;
    do begin
      @(posedge clk); #2;
      c++;
    end while ((m_stored[g] != 0 || miss[g]) && c < maxc);
    check($sformatf("i%0d_drained", g), (m_stored[g] == 0) && !miss[g], 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    int st1, st2, st3, c;
    s_valid[0] = 1'b0; s_valid[1] = 1'b0;
    s_r[0] = '0; s_r[1] = '0; s_i[0] = '0; s_i[1] = '0;
    cr[0] = 1'b1; cr[1] = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_s_ready", rdy[0], 1'b1);
    check("reset_busy", busyv[0], 1'b0);
    check("reset_issue_done", donev[0], 1'b0);
    check("reset_outputs", anyout[0], 1'b0);
    @(posedge clk); #1;

    // Single pattern matrix, core ready
    send(0, 20, 1'b1, 1'b0, st1);
    check("single_stalls", st1, 0);
    drain(0, 300);

    // Two matrices back-to-back: no stall expected
    send(0, 20, 1'b0, 1'b0, st1);
    send(0, 20, 1'b0, 1'b0, st2);
    check("b2b_stalls", st1 + st2, 0);
    drain(0, 400);

    // Three matrices with core_ready low: both banks fill after 40 beats
    cr[0] = 1'b0;
    send(0, 20, 1'b0, 1'b0, st1);
    send(0, 20, 1'b0, 1'b0, st2);
    check("two_full_stalls", st1 + st2, 0);
    s_valid[0] = 1'b0;
    @(negedge clk);
    check("s_ready_both_full", rdy[0], 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("held_not_busy", busyv[0], 1'b0);
    @(posedge clk); #1;
    cr[0] = 1'b1;
    send(0, 20, 1'b0, 1'b0, st3);
    check("third_held", st3 > 0, 1'b1);
    drain(0, 600);

    // core_ready drops mid-issue
    send(0, 20, 1'b0, 1'b0, st1);
    s_valid[0] = 1'b0;
    c = 0;
    do begin @(posedge clk); #2; c++; end while (!(miss[0] && mt[0] >= 10) && c < 100);
    check("crdrop_started", miss[0], 1'b1);
    cr[0] = 1'b0;
    drain(0, 200);
    cr[0] = 1'b1;

    // Reset at t=20 with bank 1 half loaded
    send(0, 20, 1'b1, 1'b0, st1);
    send(0, 10, 1'b0, 1'b0, st2);
    s_valid[0] = 1'b0;
    c = 0;
    do begin @(posedge clk); #2; c++; end while (!(miss[0] && mt[0] == 20) && c < 300);
    check("rst_at_t20", miss[0] && (mt[0] == 20), 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busyv[0], 1'b0);
    check("rst_mid_s_ready", rdy[0], 1'b1);
    check("rst_mid_outputs", anyout[0], 1'b0);
    @(posedge clk); #1;
    send(0, 20, 1'b0, 1'b0, st1);
    drain(0, 300);

    // Randomised data with random input gaps
    for (int m = 0; m < 5; m++) begin
      send(0, 20, 1'b0, 1'b1, st1);
      s_valid[0] = 1'b0;
      repeat ($urandom_range(0, 40)) begin @(posedge clk); #1; end
    end
    drain(0, 600);

    // N=2, SKEW=3, ROW_GAP=3 instance
    send(1, 6, 1'b1, 1'b0, st1);
    send(1, 6, 1'b0, 1'b0, st2);
    check("n2_stalls", st1 + st2, 0);
    drain(1, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
